uart_txrx: RTL and testbench
============================

Name: uart_txrx

Overview:
- Parametrised full-duplex UART transceiver. It replaces the single-wire test harness with synthesisable TX and RX engines.
- Word size, parity mode and stop-bit count are configurable at elaboration time. Bit period is set at runtime.
- Connects to fabric through AXI-Stream-style valid/ready byte channels, and drives the serial `txd` and `rxd` pins.

Parameters:
- DATA_WIDTH, 8: data bits per frame, 5..9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2. TX emits all stop bits; RX checks only the first.
- PRESCALE_WIDTH, 16: width of the `prescale` input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- prescale  in  PRESCALE_WIDTH  clock cycles per bit. Values below 4 are treated as 4.
- s_axis_tdata  in  DATA_WIDTH  TX word.
- s_axis_tvalid  in  1  TX word valid.
- s_axis_tready  out  1  TX ready to accept a word.
- m_axis_tdata  out  DATA_WIDTH  RX word.
- m_axis_tvalid  out  1  RX word valid.
- m_axis_tready  in  1  RX consumer ready.
- rxd  in  1  serial input, asynchronous to clk.
- txd  out  1  serial output, idle high.
- tx_busy  out  1  TX frame in progress.
- rx_busy  out  1  RX frame in progress.
- rx_overrun_error  out  1  one-cycle pulse.
- rx_frame_error  out  1  one-cycle pulse.
- rx_parity_error  out  1  one-cycle pulse.

Behaviour:
- Reset values, applied asynchronously while rst_n=0:
  - txd=1; s_axis_tready=0; m_axis_tvalid=0; m_axis_tdata=0.
  - busy flags and error pulses = 0.
  - rxd synchroniser flops = 1.
- First clk edge after rst_n rises: s_axis_tready=1.
- Reset mid-frame aborts both engines with no partial output.
- Prescale is latched at frame start. Changing it mid-frame has no effect on that frame.
- TX FSM states: IDLE, START, DATA, PARITY, STOP.
  - s_axis_tready=1 only in IDLE. A handshake occurs when tvalid & tready.
  - On handshake: latch tdata; tready=0 and tx_busy=1 next cycle; txd=0 (START) from the next cycle.
  - Every bit is held exactly P cycles (P = latched prescale). DATA sends DATA_WIDTH bits, LSB first.
  - PARITY state is skipped when PARITY=0. Odd mode: the bit makes the total ones count odd. Even mode: makes it even.
  - STOP drives STOP_BITS*P cycles of 1.
  - Then IDLE with tready=1 and tx_busy=0.
  - Handshake-to-handshake spacing for back-to-back words = (1+DATA_WIDTH+(PARITY!=0)+STOP_BITS)*P + 1 cycles.
- RX FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - rxd passes through a 2-flop synchroniser. All references below are to the synchronised signal.
  - IDLE → START on a synchronised low; rx_busy=1.
  - START: wait floor(P/2) cycles, then re-sample. If high, the low was a glitch: return to IDLE, no pulse, no output. If low, continue.
  - DATA, PARITY and STOP each sample once per P cycles, i.e. at bit centres.
  - First stop sample = 0 → rx_frame_error pulse, word discarded, go to WAIT_HIGH. WAIT_HIGH returns to IDLE when the line is high.
  - Parity mismatch (stop bit valid) → rx_parity_error pulse, word discarded.
  - Good word, cycle after the stop sample:
    - If m_axis_tvalid=0: load m_axis_tdata and set tvalid=1.
    - If m_axis_tvalid=1 (unconsumed): rx_overrun_error pulse, new word dropped, old tdata kept.
  - The good-word check uses tvalid after any same-cycle consumption: if m_axis_tready=1 in that cycle, the new word is loaded and no overrun occurs.
  - tvalid clears on the cycle after a handshake, unless a new word loads in that same cycle.
  - RX returns to IDLE after the first stop sample. A second stop bit is not checked, so a new start bit is accepted immediately.
- Frame error takes priority over parity error. Only one error pulse is raised per frame.
- The TX and RX engines are fully independent. Simultaneous activity on both has no interaction.

Test Plan:
- Config DATA_WIDTH=8, PARITY=2, STOP_BITS=1, prescale=16. Send 0xA5 → txd: 16 cycles low, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, parity 0, stop 1. tready low for 176 cycles; second word handshakes 177 cycles after the first.
- Loopback txd→rxd with 0x00, 0xFF, 0x5A → m_axis_tdata matches each word in order, no error pulses, tvalid rises 1 cycle after each stop-bit centre sample.
- Drive 0x3C frame with parity bit inverted → rx_parity_error single pulse, m_axis_tvalid stays 0. Drive 0x3C with stop bit 0 for 16 cycles → rx_frame_error pulse, no output, RX idle only after rxd returns high.
- Hold m_axis_tready=0, receive 0x11 then 0x22 → tdata=0x11 held, one rx_overrun_error pulse. Then raise tready → 0x11 consumed, tvalid=0.
- rxd low for 3 cycles at prescale=16 → rx_busy rises then falls within 11 cycles, no output, no error pulse.
- Assert rst_n=0 mid-TX-data-bit and mid-RX-frame → txd=1 and tvalid=0 immediately, no pulses. Next transfer of 0x81 after reset release is correct in both directions.

Source files
------------

// File: rtl/uart_txrx.sv
// Full-duplex UART: independent TX and RX engines with valid/ready byte channels.
// Frame format (data width, parity, stop bits) fixed at elaboration; bit period set by prescale.
module uart_txrx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PARITY         = 0,
  parameter int STOP_BITS      = 1,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      rxd,
  output logic                      txd,
  output logic                      tx_busy,
  output logic                      rx_busy,
  output logic                      rx_overrun_error,
  output logic                      rx_frame_error,
  output logic                      rx_parity_error
);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;

  logic [PRESCALE_WIDTH-1:0] w_presc;
  assign w_presc = (prescale < PRESCALE_WIDTH'(4)) ? PRESCALE_WIDTH'(4) : prescale;

  // ---------------- TX ----------------
  tx_state_t                 r_tx_state, w_tx_state;
  logic [PRESCALE_WIDTH-1:0] r_tx_p, w_tx_p, r_tx_cnt, w_tx_cnt;
  logic [3:0]                r_tx_bit, w_tx_bit;
  logic [DATA_WIDTH-1:0]     r_tx_shift, w_tx_shift;
  logic                      r_tx_par, w_tx_par, r_txd, w_txd, r_tx_ready, w_tx_ready;
  logic                      w_par_in;

  assign w_par_in = (PARITY == 1) ? ~^s_axis_tdata : ^s_axis_tdata;

  always_comb begin
    w_tx_state = r_tx_state;
    w_tx_p     = r_tx_p;
    w_tx_cnt   = r_tx_cnt;
    w_tx_bit   = r_tx_bit;
    w_tx_shift = r_tx_shift;
    w_tx_par   = r_tx_par;
    w_txd      = r_txd;
    w_tx_ready = r_tx_ready;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_ready = 1'b1;
        w_txd      = 1'b1;
        if (s_axis_tvalid && r_tx_ready) begin
          w_tx_ready = 1'b0;
          w_txd      = 1'b0;
          w_tx_state = TX_START;
          w_tx_p     = w_presc;
          w_tx_cnt   = w_presc - 1'b1;
          w_tx_shift = s_axis_tdata;
          w_tx_par   = w_par_in;
        end
      end
      default: begin
        if (r_tx_cnt != '0) begin
          w_tx_cnt = r_tx_cnt - 1'b1;
        end else begin
          // txd is registered, so each branch drives the level of the bit being entered
          w_tx_cnt = r_tx_p - 1'b1;
          case (r_tx_state)
            TX_START: begin
              w_tx_state = TX_DATA;
              w_tx_bit   = '0;
              w_txd      = r_tx_shift[0];
              w_tx_shift = r_tx_shift >> 1;
            end
            TX_DATA: begin
              if (r_tx_bit == 4'(DATA_WIDTH-1)) begin
                w_tx_bit = '0;
                if (PARITY != 0) begin
                  w_tx_state = TX_PARITY;
                  w_txd      = r_tx_par;
                end else begin
                  w_tx_state = TX_STOP;
                  w_txd      = 1'b1;
                end
              end else begin
                w_tx_bit   = r_tx_bit + 1'b1;
                w_txd      = r_tx_shift[0];
                w_tx_shift = r_tx_shift >> 1;
              end
            end
            TX_PARITY: begin
              w_tx_state = TX_STOP;
              w_txd      = 1'b1;
            end
            TX_STOP: begin
              if (r_tx_bit == 4'(STOP_BITS-1)) begin
                w_tx_state = TX_IDLE;
                w_tx_ready = 1'b1;
              end else begin
                w_tx_bit = r_tx_bit + 1'b1;
              end
            end
            default: w_tx_state = TX_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_p     <= '0;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_txd      <= 1'b1;
      r_tx_ready <= 1'b0;
    end else begin
      r_tx_state <= w_tx_state;
      r_tx_p     <= w_tx_p;
      r_tx_cnt   <= w_tx_cnt;
      r_tx_bit   <= w_tx_bit;
      r_tx_shift <= w_tx_shift;
      r_tx_par   <= w_tx_par;
      r_txd      <= w_txd;
      r_tx_ready <= w_tx_ready;
    end
  end

  assign txd           = r_txd;
  assign s_axis_tready = r_tx_ready;
  assign tx_busy       = (r_tx_state != TX_IDLE);

  // ---------------- RX ----------------
  rx_state_t                 r_rx_state, w_rx_state;
  logic [1:0]                r_rx_sync;
  logic [PRESCALE_WIDTH-1:0] r_rx_p, w_rx_p, r_rx_cnt, w_rx_cnt;
  logic [3:0]                r_rx_bit, w_rx_bit;
  logic [DATA_WIDTH-1:0]     r_rx_shift, w_rx_shift, r_rx_data, w_rx_data;
  logic                      r_rx_pbit, w_rx_pbit, r_rx_valid, w_rx_valid;
  logic                      r_ovr, w_ovr, r_ferr, w_ferr, r_perr, w_perr;
  logic                      w_rxd, w_rx_par_ok;

  assign w_rxd       = r_rx_sync[1];
  assign w_rx_par_ok = (PARITY == 0) ||
                       (r_rx_pbit == ((PARITY == 1) ? ~^r_rx_shift : ^r_rx_shift));

  always_comb begin
    w_rx_state = r_rx_state;
    w_rx_p     = r_rx_p;
    w_rx_cnt   = r_rx_cnt;
    w_rx_bit   = r_rx_bit;
    w_rx_shift = r_rx_shift;
    w_rx_pbit  = r_rx_pbit;
    w_rx_data  = r_rx_data;
    w_rx_valid = r_rx_valid & ~m_axis_tready;
    w_ovr      = 1'b0;
    w_ferr     = 1'b0;
    w_perr     = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (!w_rxd) begin
          w_rx_state = RX_START;
          w_rx_p     = w_presc;
          w_rx_cnt   = (w_presc >> 1) - 1'b1;
        end
      end
      RX_WAIT_HIGH: if (w_rxd) w_rx_state = RX_IDLE;
      default: begin
        if (r_rx_cnt != '0) begin
          w_rx_cnt = r_rx_cnt - 1'b1;
        end else begin
          w_rx_cnt = r_rx_p - 1'b1;
          case (r_rx_state)
            RX_START: begin
              if (w_rxd) w_rx_state = RX_IDLE;
              else begin
                w_rx_state = RX_DATA;
                w_rx_bit   = '0;
              end
            end
            RX_DATA: begin
              w_rx_shift = {w_rxd, r_rx_shift[DATA_WIDTH-1:1]};
              if (r_rx_bit == 4'(DATA_WIDTH-1))
                w_rx_state = (PARITY != 0) ? RX_PARITY : RX_STOP;
              else
                w_rx_bit = r_rx_bit + 1'b1;
            end
            RX_PARITY: begin
              w_rx_pbit  = w_rxd;
              w_rx_state = RX_STOP;
            end
            RX_STOP: begin
              if (!w_rxd) begin
                w_ferr     = 1'b1;
                w_rx_state = RX_WAIT_HIGH;
              end else begin
                w_rx_state = RX_IDLE;
                // occupancy is judged after this cycle's consumption
                if (!w_rx_par_ok) w_perr = 1'b1;
                else if (w_rx_valid) w_ovr = 1'b1;
                else begin
                  w_rx_data  = r_rx_shift;
                  w_rx_valid = 1'b1;
                end
              end
            end
            default: w_rx_state = RX_IDLE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_p     <= '0;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
      r_perr     <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], rxd};
      r_rx_state <= w_rx_state;
      r_rx_p     <= w_rx_p;
      r_rx_cnt   <= w_rx_cnt;
      r_rx_bit   <= w_rx_bit;
      r_rx_shift <= w_rx_shift;
      r_rx_pbit  <= w_rx_pbit;
      r_rx_data  <= w_rx_data;
      r_rx_valid <= w_rx_valid;
      r_ovr      <= w_ovr;
      r_ferr     <= w_ferr;
      r_perr     <= w_perr;
    end
  end

  assign m_axis_tdata     = r_rx_data;
  assign m_axis_tvalid    = r_rx_valid;
  assign rx_busy          = (r_rx_state != RX_IDLE);
  assign rx_overrun_error = r_ovr;
  assign rx_frame_error   = r_ferr;
  assign rx_parity_error  = r_perr;

endmodule

// File: tb/tb_uart_txrx.sv
// Self-checking bench for uart_txrx: 8 data bits, even parity, 1 stop bit, prescale 16.
// Received words are checked against a scoreboard queue filled when stimulus is driven.
module tb_uart_txrx;
  localparam int DW     = 8;
  localparam int P      = 16;
  localparam int RX_LAT = 3 + P / 2 + (1 + DW + 1) * P;

  logic          clk, rst_n;
  logic [15:0]   prescale;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, m_axis_tvalid, m_axis_tready;
  logic          rxd, txd, tx_busy, rx_busy;
  logic          rx_overrun_error, rx_frame_error, rx_parity_error;
  logic          rxd_drv, loop;

  int unsigned   checks = 0, errors = 0, cyc = 0;
  int unsigned   ovr_n = 0, ferr_n = 0, perr_n = 0, vrise_n = 0;
  logic [DW-1:0] exp_q[$];
  int unsigned   lat_q[$];

  assign rxd = loop ? txd : rxd_drv;

  uart_txrx #(.DATA_WIDTH(DW), .PARITY(2), .STOP_BITS(1), .PRESCALE_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .prescale(prescale),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .rxd(rxd), .txd(txd), .tx_busy(tx_busy), .rx_busy(rx_busy),
    .rx_overrun_error(rx_overrun_error), .rx_frame_error(rx_frame_error),
    .rx_parity_error(rx_parity_error));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic scoreboard_mon();
    logic prev_v;
    logic [DW-1:0] e;
    int unsigned h;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (m_axis_tvalid && !prev_v) begin
          vrise_n++;
          if (lat_q.size() > 0) begin
            h = lat_q.pop_front();
            checks++;
            if (cyc !== h + RX_LAT) begin
              errors++;
              $display("FAIL rx_latency: got %0d cycles, expected %0d", cyc - h, RX_LAT);
            end
          end
        end
        if (m_axis_tvalid && m_axis_tready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_unexpected: got word %h, expected none", m_axis_tdata);
          end else begin
            e = exp_q.pop_front();
            if (m_axis_tdata !== e) begin
              errors++;
              $display("FAIL rx_data: got %h, expected %h", m_axis_tdata, e);
            end
          end
        end
        ovr_n  += int'(rx_overrun_error);
        ferr_n += int'(rx_frame_error);
        perr_n += int'(rx_parity_error);
      end
      prev_v = m_axis_tvalid;
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int unsigned n = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL tx_handshake: tready=%b after %0d cycles, expected 1", s_axis_tready, n);
    end else if (loop) lat_q.push_back(cyc + 1);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drive_frame(input logic [DW-1:0] d, input logic par_flip, input logic stop_v);
    logic [10:0] bits;
    bits = {stop_v, (^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rxd_drv = bits[i];
      repeat (P) @(negedge clk);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b, expected 1", txd); end
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b, expected 0", s_axis_tready); end
    checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0) begin
      errors++; $display("FAIL reset_m_axis: got valid=%b data=%h, expected 0/00", m_axis_tvalid, m_axis_tdata); end
    checks++; if ({tx_busy, rx_busy, rx_overrun_error, rx_frame_error, rx_parity_error} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b, expected 00000",
                         {tx_busy, rx_busy, rx_overrun_error, rx_frame_error, rx_parity_error}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL release_tready: got %b, expected 0", s_axis_tready); end
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL first_edge_tready: got %b, expected 1", s_axis_tready); end
  endtask

  task automatic test_tx_frame();
    logic [10:0] bits;
    int unsigned n = 0;
    bits = {1'b1, ^8'hA5, 8'hA5, 1'b0};
    s_axis_tdata  = 8'hA5;
    s_axis_tvalid = 1'b1;
    checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL tx_idle_ready: got %b, expected 1", s_axis_tready); end
    for (int k = 0; k < 176; k++) begin
      @(negedge clk);
      if (k == 0) begin
        s_axis_tdata = 8'h3C;
        prescale     = 16'd7;
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy: got %b, expected 1", tx_busy); end
      end
      if (k == 100) prescale = 16'd16;
      checks++;
      if (txd !== bits[k / 16] || s_axis_tready !== 1'b0) begin
        errors++;
        $display("FAIL tx_bit k=%0d: got txd=%b tready=%b, expected txd=%b tready=0",
                 k, txd, s_axis_tready, bits[k / 16]);
      end
    end
    @(negedge clk);
    checks++; if (s_axis_tready !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL tx_end: got tready=%b busy=%b, expected 1/0", s_axis_tready, tx_busy); end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    checks++; if (txd !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++; $display("FAIL tx_back_to_back: got txd=%b tready=%b, expected 0/0", txd, s_axis_tready); end
    while (tx_busy && n < 1000) begin @(negedge clk); n++; end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL tx_drain: got busy=%b, expected 0", tx_busy); end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] words [3] = '{8'h00, 8'hFF, 8'h5A};
    int unsigned o = ovr_n, f = ferr_n, p = perr_n, n = 0;
    loop = 1'b1;
    m_axis_tready = 1'b1;
    foreach (words[i]) begin
      exp_q.push_back(words[i]);
      send_word(words[i]);
    end
    while (exp_q.size() > 0 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL loopback_drain: got %0d pending, expected 0", exp_q.size()); end
    repeat (20) @(negedge clk);
    checks++; if (ovr_n != o || ferr_n != f || perr_n != p) begin
      errors++; $display("FAIL loopback_pulses: got %0d/%0d/%0d, expected 0/0/0", ovr_n - o, ferr_n - f, perr_n - p); end
    loop = 1'b0;
  endtask

  task automatic test_rx_errors();
    int unsigned f = ferr_n, p = perr_n, v = vrise_n;
    drive_frame(8'h3C, 1'b1, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (perr_n != p + 1 || ferr_n != f || vrise_n != v) begin
      errors++; $display("FAIL parity_err: got perr=%0d ferr=%0d words=%0d, expected 1/0/0", perr_n - p, ferr_n - f, vrise_n - v); end
    repeat (10) @(negedge clk);
    f = ferr_n; p = perr_n;
    drive_frame(8'h3C, 1'b1, 1'b0);
    checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL frame_wait_high: got busy=%b, expected 1", rx_busy); end
    repeat (4) @(negedge clk);
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_idle: got busy=%b, expected 0", rx_busy); end
    checks++; if (ferr_n != f + 1 || perr_n != p || vrise_n != v || m_axis_tvalid !== 1'b0) begin
      errors++; $display("FAIL frame_err: got ferr=%0d perr=%0d words=%0d, expected 1/0/0", ferr_n - f, perr_n - p, vrise_n - v); end
  endtask

  task automatic test_overrun();
    int unsigned o = ovr_n;
    m_axis_tready = 1'b0;
    exp_q.push_back(8'h11);
    drive_frame(8'h11, 1'b0, 1'b1);
    drive_frame(8'h22, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h11) begin
      errors++; $display("FAIL overrun_hold: got valid=%b data=%h, expected 1/11", m_axis_tvalid, m_axis_tdata); end
    checks++; if (ovr_n != o + 1) begin errors++; $display("FAIL overrun_pulse: got %0d, expected 1", ovr_n - o); end
    m_axis_tready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (m_axis_tvalid !== 1'b0 || exp_q.size() != 0) begin
      errors++; $display("FAIL overrun_consume: got valid=%b pending=%0d, expected 0/0", m_axis_tvalid, exp_q.size()); end
  endtask

  task automatic test_glitch();
    int rise = -1, fall = -1;
    int unsigned o = ovr_n, f = ferr_n, p = perr_n, v = vrise_n;
    rxd_drv = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 3) rxd_drv = 1'b1;
      if (rx_busy && rise < 0) rise = i;
      if (!rx_busy && rise >= 0 && fall < 0) fall = i;
    end
    checks++; if (rise < 0 || fall < 0 || fall > 11) begin
      errors++; $display("FAIL glitch_busy: got rise=%0d fall=%0d, expected fall<=11", rise, fall); end
    checks++; if (ovr_n != o || ferr_n != f || perr_n != p || vrise_n != v) begin
      errors++; $display("FAIL glitch_quiet: got pulses=%0d words=%0d, expected 0/0", (ovr_n - o) + (ferr_n - f) + (perr_n - p), vrise_n - v); end
  endtask

  task automatic test_reset_midframe();
    int unsigned o, f, p, n = 0;
    loop = 1'b1;
    send_word(8'h55);
    repeat (60) @(negedge clk);
    checks++; if (tx_busy !== 1'b1 || rx_busy !== 1'b1) begin
      errors++; $display("FAIL midframe_busy: got tx=%b rx=%b, expected 1/1", tx_busy, rx_busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1 || m_axis_tvalid !== 1'b0 || tx_busy !== 1'b0 || rx_busy !== 1'b0) begin
      errors++; $display("FAIL midframe_reset: got txd=%b valid=%b busy=%b%b, expected 1/0/00", txd, m_axis_tvalid, tx_busy, rx_busy); end
    lat_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    o = ovr_n; f = ferr_n; p = perr_n;
    exp_q.push_back(8'h81);
    send_word(8'h81);
    while (exp_q.size() > 0 && n < 1000) begin @(negedge clk); n++; end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL post_reset_rx: got %0d pending, expected 0", exp_q.size()); end
    checks++; if (ovr_n != o || ferr_n != f || perr_n != p) begin
      errors++; $display("FAIL post_reset_pulses: got %0d/%0d/%0d, expected 0/0/0", ovr_n - o, ferr_n - f, perr_n - p); end
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b1; prescale = 16'd16;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
    rxd_drv = 1'b1; loop = 1'b0;
    fork scoreboard_mon(); join_none
    test_reset();
    test_tx_frame();
    test_loopback();
    test_rx_errors();
    test_overrun();
    test_glitch();
    test_reset_midframe();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
